// File: rtl/trap_pkg.sv
// Shared constants and state encoding for the trap/return sequencer.
// CSR addresses, mstatus field positions, default cause values.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam logic [31:0] IRQ_CAUSE_MTIMER = 32'h8000_0007;
  localparam logic [31:0] ECALL_CAUSE      = 32'd11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SAVE_EPC,
    S_SAVE_CAUSE,
    S_RD_STATUS,
    S_WR_STATUS,
    S_REDIRECT,
    S_MRET_RD,
    S_MRET_WR,
    S_MRET_REDIR
  } trap_state_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// CSR-file port bundle driven by trap_ctrl: single read/write port plus
// the mtvec/mepc values the sequencer needs for redirect targets.
interface trap_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            csr_wen;
  logic [XLEN-1:0] csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;

  modport master (
    output csr_wen, csr_addr, csr_wdata,
    input  csr_rdata, mtvec, mepc
  );

  modport slave (
    input  csr_wen, csr_addr, csr_wdata,
    output csr_rdata, mtvec, mepc
  );
endinterface

// File: rtl/trap_vec_calc.sv
// Trap vector computation. With TRAP_CTRL_VECTORED_EN defined, interrupts
// in vectored mode (mtvec[1:0] == 01) jump to base + 4*cause; else base.
module trap_vec_calc #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] cause,
  output logic [XLEN-1:0] vec_pc
);

  logic [XLEN-1:0] base;
  assign base = {mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
  // cause MSB marks an interrupt; the shift drops it along with bit XLEN-2
  always_comb begin
    vec_pc = base;
    if (mtvec[1:0] == 2'b01 && cause[XLEN-1]) begin
      vec_pc = base + {cause[XLEN-3:0], 2'b00};
    end
  end
`else
  logic unused_vec_bits;
  assign unused_vec_bits = ^{mtvec[1:0], cause};
  assign vec_pc = base;
`endif

endmodule

// File: rtl/trap_ctrl.sv
// Trap entry / mret sequencer driving the CSR file port; stalls the core
// and issues a one-cycle redirect. Optional macro: TRAP_CTRL_VECTORED_EN.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter logic [XLEN-1:0] IRQ_CAUSE = 32'h8000_0007
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exc_req,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            mret_req,
  input  logic            irq,
  input  logic [XLEN-1:0] retire_pc,
  input  logic            core_csr_wen,
  input  logic [XLEN-1:0] core_csr_addr,
  input  logic [XLEN-1:0] core_csr_wdata,
  trap_ctrl_if.master     csr,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [XLEN-1:0] A_MSTATUS = XLEN'(CSR_MSTATUS);
  localparam logic [XLEN-1:0] A_MEPC    = XLEN'(CSR_MEPC);
  localparam logic [XLEN-1:0] A_MCAUSE  = XLEN'(CSR_MCAUSE);

  function automatic logic [XLEN-1:0] trap_status(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r                                 = s;
    r[MSTATUS_MPIE]                   = s[MSTATUS_MIE];
    r[MSTATUS_MIE]                    = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mret_status(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r                                 = s;
    r[MSTATUS_MIE]                    = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE]                   = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
    return r;
  endfunction

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] epc_q, cause_q, status_q;
  logic            mie_shadow_q;

  logic            acc_exc, acc_mret, acc_irq;
  logic            wen_c, stall_c, rv_c;
  logic [XLEN-1:0] addr_c, wdata_c, rpc_c;
  logic [XLEN-1:0] vec_pc;

  trap_vec_calc #(
    .XLEN (XLEN)
  ) u_vec (
    .mtvec  (csr.mtvec),
    .cause  (cause_q),
    .vec_pc (vec_pc)
  );

  always_comb begin
    state_d  = state_q;
    acc_exc  = 1'b0;
    acc_mret = 1'b0;
    acc_irq  = 1'b0;
    wen_c    = 1'b0;
    addr_c   = '0;
    wdata_c  = '0;
    stall_c  = 1'b0;
    rv_c     = 1'b0;
    rpc_c    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (exc_req) begin
          acc_exc = 1'b1;
          stall_c = 1'b1;
          state_d = S_SAVE_EPC;
        end else if (mret_req) begin
          acc_mret = 1'b1;
          stall_c  = 1'b1;
          state_d  = S_MRET_RD;
        end else if (irq && mie_shadow_q) begin
          acc_irq = 1'b1;
          stall_c = 1'b1;
          state_d = S_SAVE_EPC;
        end else begin
          wen_c   = core_csr_wen;
          addr_c  = core_csr_addr;
          wdata_c = core_csr_wdata;
        end
      end
      S_SAVE_EPC: begin
        wen_c   = 1'b1;
        addr_c  = A_MEPC;
        wdata_c = epc_q;
        stall_c = 1'b1;
        state_d = S_SAVE_CAUSE;
      end
      S_SAVE_CAUSE: begin
        wen_c   = 1'b1;
        addr_c  = A_MCAUSE;
        wdata_c = cause_q;
        stall_c = 1'b1;
        state_d = S_RD_STATUS;
      end
      S_RD_STATUS: begin
        addr_c  = A_MSTATUS;
        stall_c = 1'b1;
        state_d = S_WR_STATUS;
      end
      S_WR_STATUS: begin
        wen_c   = 1'b1;
        addr_c  = A_MSTATUS;
        wdata_c = trap_status(status_q);
        stall_c = 1'b1;
        state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        stall_c = 1'b1;
        rv_c    = 1'b1;
        rpc_c   = vec_pc;
        state_d = S_IDLE;
      end
      S_MRET_RD: begin
        addr_c  = A_MSTATUS;
        stall_c = 1'b1;
        state_d = S_MRET_WR;
      end
      S_MRET_WR: begin
        wen_c   = 1'b1;
        addr_c  = A_MSTATUS;
        wdata_c = mret_status(status_q);
        stall_c = 1'b1;
        state_d = S_MRET_REDIR;
      end
      S_MRET_REDIR: begin
        stall_c = 1'b1;
        rv_c    = 1'b1;
        rpc_c   = csr.mepc;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, even though IDLE passthrough
  // would otherwise echo the core's CSR inputs.
  assign csr.csr_wen     = rst_n & wen_c;
  assign csr.csr_addr    = rst_n ? addr_c  : '0;
  assign csr.csr_wdata   = rst_n ? wdata_c : '0;
  assign stall           = rst_n & stall_c;
  assign redirect_valid  = rst_n & rv_c;
  assign redirect_pc     = rst_n ? rpc_c   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      epc_q        <= '0;
      cause_q      <= '0;
      status_q     <= '0;
      mie_shadow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (acc_exc) begin
            epc_q   <= exc_pc;
            cause_q <= exc_cause;
          end else if (acc_irq) begin
            epc_q   <= retire_pc;
            cause_q <= IRQ_CAUSE;
          end else if (!acc_mret && core_csr_wen && core_csr_addr == A_MSTATUS) begin
            mie_shadow_q <= core_csr_wdata[MSTATUS_MIE];
          end
        end
        S_RD_STATUS, S_MRET_RD: status_q <= csr.csr_rdata;
        S_WR_STATUS:            mie_shadow_q <= 1'b0;
        S_MRET_WR:              mie_shadow_q <= status_q[MSTATUS_MPIE];
        default: ;
      endcase
    end
  end

endmodule
